// File: rtl/powerup_scheduler.sv
// Power-up timers for large-board and speed-up, driving the display light_state.
// Optional blink of warning-phase lights: define POWERUP_BLINK_EN.
module powerup_scheduler #(
    parameter int unsigned TICK_DIV  = 50_000_000,
    parameter int unsigned LARGE_SEC = 10,
    parameter int unsigned SPEED_SEC = 8,
    parameter int unsigned WARN_SEC  = 3,
    parameter int unsigned BLINK_DIV = 12_500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       clear,
    input  logic       req_large,
    input  logic       req_speed,
    output logic [1:0] light_state,
    output logic [3:0] large_left,
    output logic [3:0] speed_left,
    output logic       large_expired,
    output logic       speed_expired
);

    localparam int unsigned   PW       = $clog2(TICK_DIV);
    localparam logic [PW-1:0] TICK_MAX = PW'(TICK_DIV - 1);
    localparam int unsigned   MIN_SEC  = (LARGE_SEC < SPEED_SEC) ? LARGE_SEC : SPEED_SEC;
    localparam logic [3:0]    DUR_L    = 4'(LARGE_SEC);
    localparam logic [3:0]    DUR_S    = 4'(SPEED_SEC);
    localparam logic [3:0]    WARN_L   = 4'(WARN_SEC);

    if (TICK_DIV < 2) begin : g_bad_tick
        $error("powerup_scheduler: TICK_DIV must be >= 2");
    end
    if (LARGE_SEC < 1 || LARGE_SEC > 15) begin : g_bad_large
        $error("powerup_scheduler: LARGE_SEC must be in 1..15");
    end
    if (SPEED_SEC < 1 || SPEED_SEC > 15) begin : g_bad_speed
        $error("powerup_scheduler: SPEED_SEC must be in 1..15");
    end
    if (WARN_SEC < 1 || WARN_SEC >= MIN_SEC) begin : g_bad_warn
        $error("powerup_scheduler: WARN_SEC must be in 1..min(LARGE_SEC,SPEED_SEC)-1");
    end
    if (BLINK_DIV < 1) begin : g_bad_blink
        $error("powerup_scheduler: BLINK_DIV must be >= 1");
    end

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_WARN} state_t;

    // Index 0 = large board, index 1 = speed up (matches light_state bit order).
    logic [PW-1:0] r_presc, w_presc_nxt;
    logic          w_sec_tick;
    state_t        r_state     [2];
    state_t        w_state_nxt [2];
    logic [3:0]    r_left      [2];
    logic [3:0]    w_left_nxt  [2];
    logic [3:0]    w_dur       [2];
    logic [1:0]    r_expired, w_exp_nxt;
    logic [1:0]    w_req;

    assign w_req      = {req_speed, req_large};
    assign w_dur[0]   = DUR_L;
    assign w_dur[1]   = DUR_S;
    assign w_sec_tick = enable && (r_presc == TICK_MAX);

    always_comb begin
        w_presc_nxt = r_presc;
        if (clear) begin
            w_presc_nxt = '0;
        end else if (enable) begin
            w_presc_nxt = w_sec_tick ? '0 : r_presc + PW'(1);
        end
    end

    always_comb begin
        w_exp_nxt = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            w_state_nxt[i] = r_state[i];
            w_left_nxt[i]  = r_left[i];
            if (clear) begin
                w_state_nxt[i] = S_IDLE;
                w_left_nxt[i]  = '0;
            end else if (w_req[i]) begin
                w_state_nxt[i] = S_ACTIVE;
                w_left_nxt[i]  = w_dur[i];
            end else if (w_sec_tick) begin
                unique case (r_state[i])
                    S_ACTIVE: begin
                        w_left_nxt[i] = r_left[i] - 4'd1;
                        if (r_left[i] - 4'd1 == WARN_L) w_state_nxt[i] = S_WARN;
                    end
                    S_WARN: begin
                        if (r_left[i] > 4'd1) begin
                            w_left_nxt[i] = r_left[i] - 4'd1;
                        end else begin
                            w_state_nxt[i] = S_IDLE;
                            w_left_nxt[i]  = '0;
                            w_exp_nxt[i]   = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc   <= '0;
            r_expired <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                r_state[i] <= S_IDLE;
                r_left[i]  <= '0;
            end
        end else begin
            r_presc   <= w_presc_nxt;
            r_expired <= w_exp_nxt;
            for (int unsigned i = 0; i < 2; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_left[i]  <= w_left_nxt[i];
            end
        end
    end

    assign large_left    = r_left[0];
    assign speed_left    = r_left[1];
    assign large_expired = r_expired[0];
    assign speed_expired = r_expired[1];

`ifdef POWERUP_BLINK_EN
    localparam int unsigned   BW        = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

    logic [BW-1:0] r_blink_cnt;
    logic          r_phase;
    logic          w_any_warn, w_blink_restart;

    // Phase restarts "on" whenever a timer enters WARN or is reloaded.
    always_comb begin
        w_any_warn      = 1'b0;
        w_blink_restart = 1'b0;
        for (int unsigned i = 0; i < 2; i++) begin
            if (r_state[i] == S_WARN) w_any_warn = 1'b1;
            if (w_state_nxt[i] == S_WARN && r_state[i] != S_WARN) w_blink_restart = 1'b1;
            if (w_req[i] && !clear) w_blink_restart = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_blink_restart || !w_any_warn) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b1;
        end else if (enable) begin
            if (r_blink_cnt == BLINK_MAX) begin
                r_blink_cnt <= '0;
                r_phase     <= ~r_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + BW'(1);
            end
        end
    end

    always_comb begin
        light_state = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            light_state[i] = (r_state[i] == S_WARN) ? r_phase : (r_state[i] != S_IDLE);
        end
    end
`else
    always_comb begin
        light_state = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            light_state[i] = (r_state[i] != S_IDLE);
        end
    end
`endif

endmodule

// File: tb/tb_powerup_scheduler.sv
// Directed bench for powerup_scheduler with small timing parameters.
module tb_powerup_scheduler;

    logic       clk = 1'b0;
    logic       rst, enable, clear, req_large, req_speed;
    logic [1:0] light_state;
    logic [3:0] large_left, speed_left;
    logic       large_expired, speed_expired;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    always #5 clk = ~clk;

    powerup_scheduler #(
        .TICK_DIV (4),
        .LARGE_SEC(5),
        .SPEED_SEC(3),
        .WARN_SEC (2),
        .BLINK_DIV(2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .clear        (clear),
        .req_large    (req_large),
        .req_speed    (req_speed),
        .light_state  (light_state),
        .large_left   (large_left),
        .speed_left   (speed_left),
        .large_expired(large_expired),
        .speed_expired(speed_expired)
    );

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reset, then three edges so the prescaler sits at TICK_DIV-1: the next
    // edge is a tick edge, matching the timings in the directed checks.
    task automatic restart();
        rst = 1'b1; enable = 1'b1; clear = 1'b0; req_large = 1'b0; req_speed = 1'b0;
        step(1);
        rst = 1'b0;
        step(3);
    endtask

    task automatic pulse(input logic l, input logic s);
        req_large = l;
        req_speed = s;
        step(1);
        req_large = 1'b0;
        req_speed = 1'b0;
    endtask

    logic [7:0] blink_pat;

    initial begin
`ifdef POWERUP_BLINK_EN
        blink_pat = 8'b0011_0011;
`else
        blink_pat = 8'hFF;
`endif
        rst = 1'b1; enable = 1'b1; clear = 1'b0; req_large = 1'b0; req_speed = 1'b0;

        // Reset state
        step(2);
        check("rst_light", 4'(light_state), 4'd0);
        check("rst_large_left", large_left, 4'd0);
        check("rst_speed_left", speed_left, 4'd0);
        check("rst_expired", 4'({large_expired, speed_expired}), 4'd0);

        // 1: single large-board run
        restart();
        pulse(1'b1, 1'b0);
        check("t1_light_start", 4'(light_state), 4'd1);
        check("t1_left_start", large_left, 4'd5);
        step(11);
        check("t1_left_p11", large_left, 4'd3);
        step(1);
        check("t1_left_warn", large_left, 4'd2);
        step(7);
        check("t1_left_p19", large_left, 4'd1);
        check("t1_exp_p19", 4'(large_expired), 4'd0);
        step(1);
        check("t1_exp_p20", 4'(large_expired), 4'd1);
        check("t1_light_p20", 4'(light_state), 4'd0);
        check("t1_left_p20", large_left, 4'd0);
        step(1);
        check("t1_exp_p21", 4'(large_expired), 4'd0);

        // 2: both granted together
        restart();
        pulse(1'b1, 1'b1);
        check("t2_light_start", 4'(light_state), 4'd3);
        check("t2_large_start", large_left, 4'd5);
        check("t2_speed_start", speed_left, 4'd3);
        step(11);
        check("t2_speed_left_p11", speed_left, 4'd1);
        check("t2_speed_exp_p11", 4'(speed_expired), 4'd0);
        step(1);
        check("t2_speed_exp_p12", 4'(speed_expired), 4'd1);
        check("t2_light_p12", 4'(light_state), 4'd1);
        check("t2_large_left_p12", large_left, 4'd2);
        step(8);
        check("t2_large_exp_p20", 4'(large_expired), 4'd1);
        check("t2_speed_exp_p20", 4'(speed_expired), 4'd0);
        check("t2_light_p20", 4'(light_state), 4'd0);

        // 3: reload at left=1 on a tick edge
        restart();
        pulse(1'b1, 1'b0);
        step(19);
        check("t3_left_p19", large_left, 4'd1);
        pulse(1'b1, 1'b0);
        check("t3_left_reload", large_left, 4'd5);
        check("t3_exp_reload", 4'(large_expired), 4'd0);
        check("t3_light_reload", 4'(light_state), 4'd1);
        step(1);
        check("t3_exp_p21", 4'(large_expired), 4'd0);
        step(3);
        check("t3_left_p24", large_left, 4'd4);

        // 4: pause for 10 cycles at left=3
        restart();
        pulse(1'b1, 1'b0);
        step(9);
        check("t4_left_p9", large_left, 4'd3);
        enable = 1'b0;
        step(10);
        check("t4_left_paused", large_left, 4'd3);
        enable = 1'b1;
        step(2);
        check("t4_left_p21", large_left, 4'd3);
        step(1);
        check("t4_left_p22", large_left, 4'd2);
        step(7);
        check("t4_exp_p29", 4'(large_expired), 4'd0);
        step(1);
        check("t4_exp_p30", 4'(large_expired), 4'd1);
        check("t4_light_p30", 4'(light_state), 4'd0);

        // 5: clear cancels everything and restarts the prescaler
        restart();
        pulse(1'b1, 1'b1);
        step(2);
        check("t5_light_before", 4'(light_state), 4'd3);
        clear = 1'b1;
        step(1);
        check("t5_light_clear", 4'(light_state), 4'd0);
        check("t5_large_clear", large_left, 4'd0);
        check("t5_speed_clear", speed_left, 4'd0);
        check("t5_exp_clear", 4'({large_expired, speed_expired}), 4'd0);
        req_speed = 1'b1;
        step(1);
        clear = 1'b0;
        req_speed = 1'b0;
        check("t5_light_clr_req", 4'(light_state), 4'd0);
        check("t5_speed_clr_req", speed_left, 4'd0);
        check("t5_exp_clr_req", 4'({large_expired, speed_expired}), 4'd0);
        pulse(1'b1, 1'b0);
        check("t5_left_g0", large_left, 4'd5);
        step(2);
        check("t5_left_g2", large_left, 4'd5);
        step(1);
        check("t5_left_g3", large_left, 4'd4);

        // 6: light bit0 through the warning window
        restart();
        pulse(1'b1, 1'b0);
        step(11);
        for (int k = 0; k < 8; k++) begin
            step(1);
            check($sformatf("t6_bit0_w%0d", k), 4'(light_state[0]), 4'(blink_pat[k]));
            check($sformatf("t6_bit1_w%0d", k), 4'(light_state[1]), 4'd0);
        end
        step(1);
        check("t6_light_end", 4'(light_state), 4'd0);
        check("t6_exp_end", 4'(large_expired), 4'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/powerup_scheduler.md
Name: powerup_scheduler

Overview:
Owns power-up timing for the brick-breaker game. Accepts one-cycle grant pulses for "large board" and "speed up", runs one countdown timer per power-up from a shared 1 s tick, and reports expiries to game logic. Drives the 2-bit light_state input of the dot-matrix display driver: bit0 = large board, bit1 = speed up, 3 = both.

Parameters:
TICK_DIV, 50_000_000, clk cycles per 1 s tick; must be >= 2.
LARGE_SEC, 10, large-board duration in seconds; range 1..15.
SPEED_SEC, 8, speed-up duration in seconds; range 1..15.
WARN_SEC, 3, final seconds treated as warning; 1 <= WARN_SEC < min(LARGE_SEC, SPEED_SEC).
BLINK_DIV, 12_500_000, clk cycles per blink half-period; used only with the optional feature.

Ports:
clk  in  1  system clock, single clock domain
rst  in  1  synchronous active-high reset
enable  in  1  game running; 0 = paused, all timers frozen
clear  in  1  round/level reset; cancels all power-ups
req_large  in  1  one-cycle grant: start or extend large board
req_speed  in  1  one-cycle grant: start or extend speed up
light_state  out  2  to the dot-matrix display driver; bit0 large, bit1 speed
large_left  out  4  whole seconds remaining, large board
speed_left  out  4  whole seconds remaining, speed up
large_expired  out  1  one-cycle pulse on natural expiry
speed_expired  out  1  one-cycle pulse on natural expiry

Behaviour:
- Priority per edge: rst > clear > req > tick countdown.
- Reset: prescaler 0, both FSMs IDLE, light_state=0, *_left=0, *_expired=0, blink phase on.
- Prescaler: counts 0..TICK_DIV-1 only while enable=1; sec_tick is asserted internally when the count is TICK_DIV-1 and enable=1, then the count wraps to 0. Holds while enable=0. Forced to 0 on clear.
- Per-power-up FSM, states IDLE, ACTIVE, WARN; DUR = LARGE_SEC or SPEED_SEC:
  - IDLE + req -> ACTIVE, left <= DUR.
  - ACTIVE + sec_tick -> left-1; enter WARN when the new left equals WARN_SEC.
  - WARN + sec_tick with left > 1 -> left-1.
  - WARN + sec_tick with left == 1 -> IDLE, left <= 0, *_expired high for exactly the next cycle.
  - ACTIVE/WARN + req -> ACTIVE, left <= DUR. Reload, not additive. Req wins over a same-cycle sec_tick, and no expired pulse is generated.
  - Any state + clear -> IDLE, left <= 0, no expired pulse. A same-cycle req is ignored.
  - enable=0 does not block req or clear; only the countdown freezes.
- The two FSMs are independent. Simultaneous requests, or simultaneous expiries, are both honoured in the same cycle.
- Outputs are decoded from state registers. light_state bit = (state != IDLE). A req sampled at edge N is visible after edge N; expiry clears the bit after the same edge that raises *_expired.
- Widths: left is 4-bit unsigned and never underflows. Prescaler width is $clog2(TICK_DIV); blink counter width is $clog2(BLINK_DIV).
- Elaboration error if any parameter is out of its stated range.

Optional Feature:
POWERUP_BLINK_EN
- Defined: while at least one FSM is in WARN, a blink counter toggles a phase bit every BLINK_DIV cycles. The counter advances only while enable=1. Phase is forced on, and the counter restarted, whenever any FSM enters WARN or is reloaded. A light_state bit whose FSM is in WARN equals the phase bit; ACTIVE bits stay steady 1.
- Undefined: no blink logic; light_state bits stay steady 1 through WARN.

Test Plan:
Params for all scenarios: TICK_DIV=4, LARGE_SEC=5, SPEED_SEC=3, WARN_SEC=2, BLINK_DIV=2; enable=1 unless stated.
1. rst then req_large pulse -> next cycle light_state=1, large_left=5; large_left reaches 2 (WARN) after 12 cycles; large_expired is a single pulse 20 cycles after the req; light_state=0 on the same cycle.
2. req_large and req_speed in the same cycle -> light_state=3; speed_expired at +12 cycles with light_state=1; large_expired at +20 cycles with light_state=0.
3. Re-pulse req_large while large_left=1, same cycle as sec_tick -> large_left=5, state ACTIVE, no large_expired pulse, light_state bit0 stays 1.
4. enable=0 for 10 cycles mid-run with large_left=3 -> large_left holds 3, prescaler holds; expiry is delayed by exactly 10 cycles.
5. clear while both active -> next cycle light_state=0, both *_left=0, no expired pulses; clear plus req_speed in one cycle -> speed stays IDLE.
6. POWERUP_BLINK_EN defined, large in WARN -> light_state bit0 follows 1,1,0,0,1,1... from WARN entry; undefined -> bit0 steady 1 until expiry.
